// File: rtl/data_mem_bus.sv
// Data-side memory stage: byte-lane RAM, MMIO window (GPIO, cycle counter, 8N1 UART TX)
// with combinational, side-effect-free loads.
`ifndef MEM_LB
`define MEM_LB  3'd0
`define MEM_LH  3'd1
`define MEM_LW  3'd2
`define MEM_LBU 3'd3
`define MEM_LHU 3'd4
`define MEM_SB  3'd5
`define MEM_SH  3'd6
`define MEM_SW  3'd7
`endif

module data_mem_bus #(
   parameter int DATA_LEN     = 32,
   parameter int RAM_AW       = 10,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          mem_fn,
   input  logic [DATA_LEN-1:0] addr,
   input  logic [DATA_LEN-1:0] wdata,
   output logic [DATA_LEN-1:0] rdata,
   output logic [7:0]          gpio_out,
   output logic                uart_tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic                ram_sel;
   logic                mmio_sel;
   logic                is_store;
   logic [25:0]         mmio_off;
   logic [RAM_AW-1:0]   word_idx;
   logic [3:0]          lane_we;
   logic [DATA_LEN-1:0] lane_data;
   logic [3:0][7:0]     ram [2**RAM_AW];
   logic [DATA_LEN-1:0] cycle;
   logic                gpio_we;
   logic                utx_we;

   assign ram_sel  = addr[DATA_LEN-1 -: 4] == 4'h0;
   assign mmio_sel = addr[DATA_LEN-1 -: 4] == 4'h1;
   assign mmio_off = addr[27:2];
   assign word_idx = addr[RAM_AW+1:2];
   assign is_store = mem_fn inside {`MEM_SB, `MEM_SH, `MEM_SW};
   assign gpio_we  = is_store && mmio_sel && (mmio_off == 26'd0);
   assign utx_we   = is_store && mmio_sel && (mmio_off == 26'd2);

   always_comb begin
      lane_we   = '0;
      lane_data = wdata;
      case (mem_fn)
         `MEM_SW: lane_we = '1;
         `MEM_SH: begin
            lane_we   = addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
         end
         `MEM_SB: begin
            lane_we   = 4'b0001 << addr[1:0];
            lane_data = {4{wdata[7:0]}};
         end
         default: ;
      endcase
      if (!ram_sel) lane_we = '0;
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (lane_we[i]) ram[word_idx][i] <= lane_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_out <= '0;
         cycle    <= '0;
      end else begin
         cycle <= cycle + 1'b1;
         if (gpio_we) gpio_out <= wdata[7:0];
      end
   end

   uart_state_t state, state_nx;
   logic [CW-1:0] baud, baud_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          baud_done;
   logic          busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nx;
         baud    <= baud_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      baud_nx    = baud;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      uart_tx    = 1'b1;
      baud_done  = (baud == '0);
      busy       = (state != IDLE);
      case (state)
         IDLE: ;
         START: begin
            uart_tx = 1'b0;
            if (baud_done) begin
               state_nx   = DATA;
               baud_nx    = BAUD_RELOAD;
               bit_idx_nx = '0;
            end else begin
               baud_nx = baud - 1'b1;
            end
         end
         DATA: begin
            uart_tx = shreg[bit_idx];
            if (baud_done) begin
               baud_nx = BAUD_RELOAD;
               if (bit_idx == 3'd7) state_nx = STOP;
               else bit_idx_nx = bit_idx + 1'b1;
            end else begin
               baud_nx = baud - 1'b1;
            end
         end
         STOP: begin
            if (baud_done) state_nx = IDLE;
            else baud_nx = baud - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
      // The edge that ends the stop bit can also accept the next frame.
      if (utx_we && (state == IDLE || (state == STOP && baud_done))) begin
         state_nx   = START;
         baud_nx    = BAUD_RELOAD;
         bit_idx_nx = '0;
         shreg_nx   = wdata[7:0];
      end
   end

   logic [DATA_LEN-1:0] mmio_word;
   logic [DATA_LEN-1:0] word;
   logic [15:0]         half;
   logic [7:0]          byte_v;

   always_comb begin
      mmio_word = '0;
      case (mmio_off)
         26'd0:   mmio_word = DATA_LEN'(gpio_out);
         26'd1:   mmio_word = cycle;
         26'd3:   mmio_word = DATA_LEN'(busy);
         default: ;
      endcase
      word = '0;
      if (ram_sel) word = ram[word_idx];
      else if (mmio_sel) word = mmio_word;
      half = addr[1] ? word[31:16] : word[15:0];
      case (addr[1:0])
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      case (mem_fn)
         `MEM_LB:  rdata = {{(DATA_LEN-8){byte_v[7]}}, byte_v};
         `MEM_LBU: rdata = {{(DATA_LEN-8){1'b0}}, byte_v};
         `MEM_LH:  rdata = {{(DATA_LEN-16){half[15]}}, half};
         `MEM_LHU: rdata = {{(DATA_LEN-16){1'b0}}, half};
         default:  rdata = word;
      endcase
   end

endmodule

// File: tb/tb_data_mem_bus.sv
// Scoreboard bench for data_mem_bus: a driver pushes expected values from a byte-level
// reference model, a negedge monitor pops and compares.
`ifndef MEM_LB
`define MEM_LB  3'd0
`define MEM_LH  3'd1
`define MEM_LW  3'd2
`define MEM_LBU 3'd3
`define MEM_LHU 3'd4
`define MEM_SB  3'd5
`define MEM_SH  3'd6
`define MEM_SW  3'd7
`endif

module tb_data_mem_bus;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam logic [31:0] A_GPIO = 32'h1000_0000;
   localparam logic [31:0] A_CYC  = 32'h1000_0004;
   localparam logic [31:0] A_UTX  = 32'h1000_0008;
   localparam logic [31:0] A_STAT = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  mem_fn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_out;
   logic        uart_tx;

   data_mem_bus #(.DATA_LEN(32), .RAM_AW(10), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .mem_fn(mem_fn), .addr(addr), .wdata(wdata),
      .rdata(rdata), .gpio_out(gpio_out), .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk_r;
      logic [31:0] r;
      logic        tx;
      logic [7:0]  gpio;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   logic [7:0]  mem_m [4096];
   logic [7:0]  gpio_m;
   logic [31:0] cyc_m;
   bit          act_m;
   int          age_m;
   logic [7:0]  ubyte_m;

   logic [2:0]  r_fn;
   logic [31:0] r_a;
   int unsigned r_sel;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic tx_model();
      logic [7:0] s;
      if (!act_m) return 1'b1;
      if (age_m < CPB) return 1'b0;
      if (age_m < 9 * CPB) begin
         s = ubyte_m >> (age_m / CPB - 1);
         return s[0];
      end
      return 1'b1;
   endfunction

   function automatic logic [31:0] word_model(logic [31:0] a);
      int unsigned base;
      logic [31:0] off;
      if (a[31:28] == 4'h0) begin
         base = int'(a[11:0]) & ~32'd3;
         return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
      end
      if (a[31:28] == 4'h1) begin
         off = (a - 32'h1000_0000) >> 2;
         if (off == 0) return {24'b0, gpio_m};
         if (off == 1) return cyc_m;
         if (off == 3) return act_m ? 32'd1 : 32'd0;
      end
      return 32'd0;
   endfunction

   function automatic logic [31:0] load_model(logic [2:0] fn, logic [31:0] a);
      logic [31:0] w, b, h;
      w = word_model(a);
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (fn)
         `MEM_LB:  return (b >= 128) ? b - 32'd256 : b;
         `MEM_LBU: return b;
         `MEM_LH:  return (h >= 32768) ? h - 32'd65536 : h;
         `MEM_LHU: return h;
         default:  return w;
      endcase
   endfunction

   task automatic model_store(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
      int unsigned n, base;
      if (a[31:28] == 4'h0) begin
         n    = (fn == `MEM_SW) ? 4 : (fn == `MEM_SH) ? 2 : 1;
         base = int'(a[11:0]) & ~(n - 1);
         for (int unsigned i = 0; i < n; i++) mem_m[base+i] = 8'(d >> (8 * i));
      end else if (a[31:28] == 4'h1) begin
         if ((a >> 2) == (A_GPIO >> 2)) gpio_m = d[7:0];
         if ((a >> 2) == (A_UTX >> 2) && (!act_m || age_m >= FRAME - 1)) begin
            act_m   = 1'b1;
            age_m   = -1;
            ubyte_m = d[7:0];
         end
      end
   endtask

   // One command per cycle; called just after a rising edge.
   task automatic step(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d,
                       input bit use_c, input logic [31:0] c);
      exp_t e;
      bit   st;
      st     = fn inside {`MEM_SB, `MEM_SH, `MEM_SW};
      mem_fn = fn;
      addr   = a;
      wdata  = d;
      e.chk_r = !st;
      e.r     = use_c ? c : load_model(fn, a);
      e.tx    = tx_model();
      e.gpio  = gpio_m;
      sb.push_back(e);
      if (st) model_store(fn, a, d);
      @(posedge clk);
      #1;
      cyc_m++;
      if (act_m) begin
         age_m++;
         if (age_m >= FRAME) act_m = 1'b0;
      end
   endtask

   task automatic do_reset();
      mem_fn = `MEM_LW;
      addr   = A_STAT;
      #2 reset = 1'b1;
      #1;
      check("reset uart_tx", {31'b0, uart_tx}, 32'd1);
      check("reset gpio_out", {24'b0, gpio_out}, 32'd0);
      check("reset stat", rdata, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      gpio_m = '0;
      cyc_m  = '0;
      act_m  = 1'b0;
      age_m  = 0;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         if (mon_e.chk_r) check($sformatf("rdata fn%0d@%08h", mem_fn, addr), rdata, mon_e.r);
         check("uart_tx", {31'b0, uart_tx}, {31'b0, mon_e.tx});
         check("gpio_out", {24'b0, gpio_out}, {24'b0, mon_e.gpio});
      end
   end

   initial begin
      reset = 1'b1; mem_fn = `MEM_LB; addr = '0; wdata = '0;
      gpio_m = '0; cyc_m = '0; act_m = 1'b0; age_m = 0; ubyte_m = '0;
      @(posedge clk); #1;
      do_reset();

      for (int i = 0; i < 5; i++) step(`MEM_LW, A_CYC, 0, 1, 32'(i));

      for (int unsigned i = 0; i < 1024; i++) step(`MEM_SW, i * 4, $urandom, 0, 0);

      step(`MEM_SW, 32'h100, 32'h8000_00FF, 0, 0);
      step(`MEM_SB, 32'h102, 32'h0000_005A, 0, 0);
      step(`MEM_SH, 32'h100, 32'h0000_BEEF, 0, 0);
      step(`MEM_LW,  32'h100, 0, 1, 32'h805A_BEEF);
      step(`MEM_LB,  32'h102, 0, 1, 32'h0000_005A);
      step(`MEM_LH,  32'h100, 0, 1, 32'hFFFF_BEEF);
      step(`MEM_LHU, 32'h100, 0, 1, 32'h0000_BEEF);
      step(`MEM_LBU, 32'h103, 0, 1, 32'h0000_0080);
      step(`MEM_LB,  32'h103, 0, 1, 32'hFFFF_FF80);

      step(`MEM_SW, 32'h0000_1000, 32'h11, 0, 0);
      step(`MEM_LW, 32'h0, 0, 1, 32'h11);
      step(`MEM_SW, 32'h3000_0000, 32'hDEAD_BEEF, 0, 0);
      step(`MEM_LW, 32'h0, 0, 1, 32'h11);
      step(`MEM_LW, 32'h2000_0000, 0, 1, 32'h0);
      step(`MEM_SW, 32'h104, 32'h1234_5678, 0, 0);
      step(`MEM_LW, 32'h106, 0, 1, 32'h1234_5678);

      step(`MEM_SB, A_GPIO + 1, 32'hFFFF_FFA5, 0, 0);
      step(`MEM_LW, A_GPIO, 0, 1, 32'h0000_00A5);
      step(`MEM_LW, 32'h1000_0010, 0, 1, 32'h0);
      step(`MEM_LW, A_UTX, 0, 1, 32'h0);

      step(`MEM_SB, A_UTX, 32'h55, 0, 0);
      for (int j = 0; j < 45; j++) begin
         if (j == 10) step(`MEM_SB, A_UTX, 32'hFF, 0, 0);
         else step(`MEM_LW, A_STAT, 0, 1, (j < 40) ? 32'd1 : 32'd0);
      end

      step(`MEM_SB, A_UTX, 32'h0F, 0, 0);
      for (int j = 0; j < 39; j++) step(`MEM_LW, A_STAT, 0, 1, 32'd1);
      step(`MEM_SB, A_UTX, 32'hC3, 0, 0);
      for (int j = 0; j < 42; j++) step(`MEM_LW, A_STAT, 0, 1, (j < 40) ? 32'd1 : 32'd0);

      step(`MEM_SB, A_UTX, 32'h3C, 0, 0);
      for (int j = 0; j < 15; j++) step(`MEM_LW, A_STAT, 0, 1, 32'd1);
      do_reset();
      step(`MEM_LW, A_STAT, 0, 1, 32'd0);
      step(`MEM_LW, A_CYC, 0, 1, 32'd1);
      step(`MEM_SB, A_UTX, 32'h96, 0, 0);
      for (int j = 0; j < 42; j++) step(`MEM_LW, A_STAT, 0, 1, (j < 40) ? 32'd1 : 32'd0);

      for (int n = 0; n < 400; n++) begin
         r_fn  = 3'($urandom_range(0, 7));
         r_sel = $urandom_range(0, 9);
         if (r_sel < 7)      r_a = {4'h0, 28'($urandom)};
         else if (r_sel < 9) r_a = A_GPIO | ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
         else                r_a = {4'($urandom_range(2, 15)), 28'($urandom)};
         step(r_fn, r_a, $urandom, 0, 0);
      end

      step(`MEM_LB, 32'h0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
